// File: rtl/photonic_tx_serializer_pkg.sv
// rtl/photonic_tx_serializer_pkg.sv - shared types and constants for the photonic transmit serializer
package photonic_tx_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam int FLIT_W           = 8;
    localparam int PKT_W            = 32;
    localparam int FLITS_PER_PACKET = 4;
    localparam int GAP_CYCLES       = 1;

endpackage

// File: rtl/photonic_tx_serializer_fifo.sv
// rtl/photonic_tx_serializer_fifo.sv - show-ahead packet FIFO feeding the serializer
module packet_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    // A full FIFO never takes a push, even when the head leaves in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/photonic_tx_serializer.sv
// rtl/photonic_tx_serializer.sv - frames 32-bit packets into header+4 byte flits on the photonic lane
module photonic_tx_serializer #(
    parameter int FIFO_DEPTH = 4,
    parameter int FLIT_W     = photonic_tx_serializer_pkg::FLIT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       node_id,
    input  logic [31:0]       tx_packet,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [FLIT_W-1:0] link_flit,
    output logic              link_valid,
    output logic              link_sop,
    output logic              link_eop,
    input  logic              link_ready,
    output logic [15:0]       frames_sent
);

    import photonic_tx_serializer_pkg::*;

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t            state;
    logic [1:0]        byte_idx;
    logic [1:0]        gap_cnt;
    logic [PKT_W-1:0]  shreg;
    logic [PKT_W-1:0]  head;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic              push;
    logic              pop;
    logic              unused_node_bits;

    assign unused_node_bits = ^{node_id[15:FLIT_W], count};

    assign tx_ready = !full;
    assign push     = tx_valid && tx_ready;
    // The FIFO slot is released as soon as the header leaves; the shift register owns the packet after that.
    assign pop      = (state == HEADER) && link_valid && link_ready;

    packet_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (tx_packet),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            byte_idx    <= '0;
            gap_cnt     <= '0;
            shreg       <= '0;
            link_flit   <= '0;
            link_valid  <= 1'b0;
            link_sop    <= 1'b0;
            link_eop    <= 1'b0;
            frames_sent <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        state      <= HEADER;
                        link_valid <= 1'b1;
                        link_sop   <= 1'b1;
                        link_flit  <= node_id[FLIT_W-1:0];
                    end
                end
                HEADER: begin
                    if (link_ready) begin
                        state     <= PAYLOAD;
                        link_sop  <= 1'b0;
                        link_eop  <= 1'b0;
                        link_flit <= head[PKT_W-1 -: FLIT_W];
                        shreg     <= head << FLIT_W;
                        byte_idx  <= '0;
                    end
                end
                PAYLOAD: begin
                    if (link_ready) begin
                        if (byte_idx == 2'(FLITS_PER_PACKET - 1)) begin
                            state       <= GAP;
                            link_valid  <= 1'b0;
                            link_eop    <= 1'b0;
                            link_flit   <= '0;
                            byte_idx    <= '0;
                            gap_cnt     <= '0;
                            frames_sent <= frames_sent + 16'd1;
                        end else begin
                            link_flit <= shreg[PKT_W-1 -: FLIT_W];
                            shreg     <= shreg << FLIT_W;
                            byte_idx  <= byte_idx + 2'd1;
                            link_eop  <= (byte_idx == 2'(FLITS_PER_PACKET - 2));
                        end
                    end
                end
                GAP: begin
                    // Laser turn-around; a waiting packet starts its header straight after so frames take 6 cycles.
                    if (gap_cnt == 2'(GAP_CYCLES - 1)) begin
                        gap_cnt <= '0;
                        if (!empty) begin
                            state      <= HEADER;
                            link_valid <= 1'b1;
                            link_sop   <= 1'b1;
                            link_flit  <= node_id[FLIT_W-1:0];
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/photonic_tx_serializer.md
PHOTONIC_TX_SERIALIZER -- requirements
Module: photonic_tx_serializer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of 32-bit packets buffered; power of two, at least 2.
REQ-002 Parameter FLIT_W, default 8, photonic lane width in bits; fixed to 8 in this revision.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 node_id  input  16  local node number; only bits [7:0] are used, for the header flit.
REQ-006 tx_packet  input  32  outgoing data-plane packet from the node's data_tx_packet.
REQ-007 tx_valid  input  1  tx_packet holds a packet for this cycle.
REQ-008 tx_ready  output  1  FIFO can accept a packet this cycle.
REQ-009 link_flit  output  8  flit driven onto the photonic lane.
REQ-010 link_valid  output  1  link_flit is valid this cycle.
REQ-011 link_sop  output  1  current flit is the header flit.
REQ-012 link_eop  output  1  current flit is the last payload flit.
REQ-013 link_ready  input  1  lane accepts the current flit this cycle.
REQ-014 frames_sent  output  16  count of completed frames, wraps modulo 2^16.

Function
REQ-015 A push occurs when tx_valid and tx_ready are both high; tx_packet is written to the FIFO tail.
REQ-016 tx_ready equals NOT full, combinationally from the FIFO count.
REQ-017 When the FIFO is full, a same-cycle pop does not enable a push.
REQ-018 A flit transfer occurs when link_valid and link_ready are both high.
REQ-019 Each packet produces one 5-flit frame:
- H = node_id[7:0]
- then tx_packet[31:24], [23:16], [15:8], [7:0]
REQ-020 FSM states:
- IDLE: go to HEADER when the FIFO is not empty.
- HEADER: go to PAYLOAD when the header flit transfers; the FIFO head pops on that transfer.
- PAYLOAD: 2-bit byte index 0..3; after byte 3 transfers, go to GAP.
- GAP: one cycle with link_valid low for laser turn-around, then IDLE.
REQ-021 The packet being serialized is held in a 32-bit shift register loaded at the header transfer. The FIFO slot is freed at the header, not at the end of the frame.
REQ-022 link_valid is high only in HEADER and PAYLOAD.
REQ-023 link_sop is high only in HEADER; link_eop is high only in PAYLOAD with byte index 3.
REQ-024 If link_ready is low, link_flit, link_sop, link_eop and the FSM state hold unchanged until a transfer.
REQ-025 link_flit is 0 whenever link_valid is low.
REQ-026 Minimum latency: a push into an empty FIFO in cycle N gives the header flit in cycle N+2 (IDLE sees non-empty at N+1 and enters HEADER).
REQ-027 With back-to-back packets and link_ready held high, the lane carries 5 valid flits then 1 gap cycle, i.e. 6 cycles per frame.
REQ-028 frames_sent increments on the eop transfer.
REQ-029 A push and a pop in the same cycle leave the count unchanged. The FIFO pointers wrap modulo FIFO_DEPTH.
REQ-030 Empty FIFO in IDLE: the FSM stays in IDLE with no output activity.
REQ-031 No packet is dropped or duplicated under any link_ready pattern.

Reset
REQ-032 Asserting rst (low) at any time, including mid-frame, immediately clears:
- FIFO pointers and count, and the shift register
- FSM to IDLE, byte index to 0, frames_sent to 0
- link_valid, link_sop and link_eop to 0; link_flit to 0
REQ-033 tx_ready is 1 after reset; a partially sent frame is abandoned and not resumed.
REQ-034 Reset release is synchronous to clk; the first push is accepted on the first rising edge with rst high.

Structure
REQ-035 A shared package holds:
- FSM state enum (IDLE, HEADER, PAYLOAD, GAP)
- FLIT_W and FLITS_PER_PACKET = 4
- the GAP_CYCLES = 1 constant
REQ-036 The FIFO is a separate sub-module, packet_fifo, parameterised by width and depth, exposing:
- push, pop
- full, empty, count
- head data, visible while non-empty (show-ahead)

Verification
REQ-037 Bench scenario, single frame:
- Stimulus: node_id=5, push 32'hDEADBEEF at cycle 0, link_ready=1.
- Response: flits 05,DE,AD,BE,EF in cycles 2-6; sop on 05, eop on EF; frames_sent=1.
REQ-038 Bench scenario, fill:
- Stimulus: push 5 packets back-to-back with link_ready=0.
- Response: tx_ready=0 after 4 accepted; 5th held. Release link_ready and all 5 frames emerge in order, each followed by a gap cycle.
REQ-039 Bench scenario, stalls:
- Stimulus: toggle link_ready randomly during 3 frames of 32'h01234567, 32'h89ABCDEF, 32'h0.
- Response: flits unchanged while stalled; byte order exact; frames_sent=3.
REQ-040 Bench scenario, simultaneous push and pop:
- Stimulus: FIFO full and the header transfers in the same cycle as tx_valid=1.
- Response: push refused that cycle, accepted the next cycle; count stays ≤4.
REQ-041 Bench scenario, reset mid-frame:
- Stimulus: assert rst during PAYLOAD byte 2.
- Response: all outputs 0 immediately, tx_ready=1 after release; a new push produces a complete fresh frame.
REQ-042 Bench scenario, counter wrap:
- Stimulus: force 65536 frames, or preload the counter in simulation.
- Response: frames_sent wraps to 0.
